// File: rtl/dual_issue_fetch_if.sv
// Fetch/issue bundle: instruction-memory port, branch-unit controls and the two issue slots.
// Latency: none, wires only.
// Backpressure: stall_in from the pipelines; redirect_in from the branch unit.
interface dual_issue_fetch_if;
    logic        imem_req_out;
    logic [7:0]  imem_addr0_out;
    logic [7:0]  imem_addr1_out;
    logic [15:0] imem_rdata0_in;
    logic [15:0] imem_rdata1_in;
    logic        stall_in;
    logic        redirect_in;
    logic [7:0]  redirect_pc_in;
    logic [15:0] p0_IR_out;
    logic [7:0]  p0_PC_out;
    logic        p0_valid_out;
    logic [15:0] p1_IR_out;
    logic [7:0]  p1_PC_out;
    logic        p1_valid_out;
    logic        halted_out;

    modport master (
        output imem_req_out, imem_addr0_out, imem_addr1_out,
        input  imem_rdata0_in, imem_rdata1_in,
        input  stall_in, redirect_in, redirect_pc_in,
        output p0_IR_out, p0_PC_out, p0_valid_out,
        output p1_IR_out, p1_PC_out, p1_valid_out,
        output halted_out
    );

    modport slave (
        input  imem_req_out, imem_addr0_out, imem_addr1_out,
        output imem_rdata0_in, imem_rdata1_in,
        output stall_in, redirect_in, redirect_pc_in,
        input  p0_IR_out, p0_PC_out, p0_valid_out,
        input  p1_IR_out, p1_PC_out, p1_valid_out,
        input  halted_out
    );
endinterface

// File: rtl/dual_issue_fetch.sv
// Dual-issue front end: fetches word pairs into a {PC,IR} queue and issues 0/1/2 per cycle.
// Latency: request -> push 1 cycle, push -> issue 1 cycle (fetch to issue 3 edges minimum).
// Backpressure: stall_in freezes issue registers and pops; fetch throttled so the queue never overflows.
module dual_issue_fetch #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    dual_issue_fetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] TWO = CW'(2);

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] ir;
    } entry_t;

    entry_t          q [DEPTH];
    logic [AW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic [7:0]      fpc, req_pc;
    logic            inflight, drop, halted;
    entry_t          s0_r, s1_r;
    logic            v0_r, v1_r;

    entry_t          e0, e1;
    logic            hazard, v0_n, v1_n, push_en, fetch_req;
    logic [CW-1:0]   pop_n;

    function automatic logic is_ctrl(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b010) || (op == 3'b111);
    endfunction

    function automatic logic writes_reg(input logic [15:0] ir);
        return ((ir[15:13] == 3'b101) && (ir[12:11] != 2'b01)) ||
               (ir[15:13] == 3'b110) || (ir[15:13] == 3'b011);
    endfunction

    function automatic logic [2:0] dest(input logic [15:0] ir);
        return ((ir[15:13] == 3'b110) && (ir[12:11] == 2'b10)) ? ir[10:8] : ir[7:5];
    endfunction

    // Pairing decision, pop count and fetch throttle from pre-update state.
    always_comb begin
        e0        = q[head];
        e1        = q[head + AW'(1)];
        hazard    = writes_reg(e0.ir) &&
                    ((dest(e0.ir) == e1.ir[10:8]) || (dest(e0.ir) == e1.ir[7:5]) ||
                     (dest(e0.ir) == e1.ir[2:0]));
        v0_n      = (count != '0);
        v1_n      = (count >= TWO) && !is_ctrl(e0.ir[15:13]) && !is_ctrl(e1.ir[15:13]) && !hazard;
        pop_n     = '0;
        if (!bus.stall_in && !halted)
            pop_n = CW'(v0_n) + CW'(v1_n);
        push_en   = inflight && !drop;
        fetch_req = rst && !halted && !bus.redirect_in &&
                    ((32'(count) + (inflight ? 32'd2 : 32'd0)) <= 32'(DEPTH - 2));
    end

    // Control state: pointers, fetch PC, in-flight tracking and issue registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fpc      <= '0;
            req_pc   <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b0;
            drop     <= 1'b0;
            halted   <= 1'b0;
            s0_r     <= '0;
            s1_r     <= '0;
            v0_r     <= 1'b0;
            v1_r     <= 1'b0;
        end else if (bus.redirect_in) begin
            fpc      <= bus.redirect_pc_in;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b0;
            drop     <= 1'b1;
            halted   <= 1'b0;
            s0_r     <= '0;
            s1_r     <= '0;
            v0_r     <= 1'b0;
            v1_r     <= 1'b0;
        end else begin
            drop     <= 1'b0;
            inflight <= fetch_req;
            if (fetch_req) begin
                req_pc <= fpc;
                fpc    <= fpc + 8'd2;
            end
            if (push_en)
                tail <= tail + AW'(2);
            head  <= head + pop_n[AW-1:0];
            count <= count + (push_en ? TWO : '0) - pop_n;
            if (!bus.stall_in) begin
                if (halted) begin
                    s0_r <= '0;
                    s1_r <= '0;
                    v0_r <= 1'b0;
                    v1_r <= 1'b0;
                end else begin
                    v0_r <= v0_n;
                    v1_r <= v1_n;
                    s0_r <= v0_n ? e0 : '0;
                    s1_r <= v1_n ? e1 : '0;
                    if (v0_n && (e0.ir[15:13] == 3'b111))
                        halted <= 1'b1;
                end
            end
        end
    end

    // Queue storage: returned pair written at the tail, tagged with the request PC.
    always_ff @(posedge clk) begin
        if (rst && !bus.redirect_in && push_en) begin
            q[tail]          <= {req_pc, bus.imem_rdata0_in};
            q[tail + AW'(1)] <= {req_pc + 8'd1, bus.imem_rdata1_in};
        end
    end

    assign bus.imem_req_out   = fetch_req;
    assign bus.imem_addr0_out = fetch_req ? fpc : 8'h00;
    assign bus.imem_addr1_out = fetch_req ? (fpc + 8'd1) : 8'h00;
    assign bus.p0_IR_out      = s0_r.ir;
    assign bus.p0_PC_out      = s0_r.pc;
    assign bus.p0_valid_out   = v0_r;
    assign bus.p1_IR_out      = s1_r.ir;
    assign bus.p1_PC_out      = s1_r.pc;
    assign bus.p1_valid_out   = v1_r;
    assign bus.halted_out     = halted;
endmodule

// File: tb/tb_dual_issue_fetch.sv
// Bench for dual_issue_fetch: directed scenarios plus random stimulus against a queue-based model.
// Latency: model predicts request signals per cycle and issue outputs per edge.
// Backpressure: random stall_in / redirect_in / reset mixed into the random phase.
module tb_dual_issue_fetch;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dual_issue_fetch_if bus();
    dual_issue_fetch #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] ir;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mem [256];

    ent_t        mq[$];
    logic [7:0]  m_fpc, m_pend_pc;
    bit          m_pend, m_halt, m_v0, m_v1;
    ent_t        m_s0, m_s1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] f,
                                        input logic [2:0] a, input logic [2:0] b,
                                        input logic [4:0] lo);
        return {op, f, a, b, lo};
    endfunction

    function automatic bit is_ctrl(input logic [15:0] ir);
        return ir[15:13] inside {3'd1, 3'd2, 3'd7};
    endfunction

    function automatic bit wr(input logic [15:0] ir);
        return (ir[15:13] == 3'd5 && ir[12:11] != 2'b01) || ir[15:13] == 3'd6 || ir[15:13] == 3'd3;
    endfunction

    function automatic logic [2:0] dst(input logic [15:0] ir);
        return (ir[15:13] == 3'd6 && ir[12:11] == 2'b10) ? ir[10:8] : ir[7:5];
    endfunction

    function automatic bit pairable(input ent_t a, input ent_t b);
        bit raw;
        raw = wr(a.ir) && (dst(a.ir) == b.ir[10:8] || dst(a.ir) == b.ir[7:5] || dst(a.ir) == b.ir[2:0]);
        return !is_ctrl(a.ir) && !is_ctrl(b.ir) && !raw;
    endfunction

    task automatic model_clear_slots();
        m_s0 = '0; m_s1 = '0; m_v0 = 0; m_v1 = 0;
    endtask

    // One clock cycle: drive controls, check request outputs, advance model, check issue outputs.
    task automatic step(input bit st, input bit rd, input logic [7:0] rpc);
        bit         exp_req, dreq;
        logic [7:0] nxt, da0, da1, p1;
        bus.stall_in       = st;
        bus.redirect_in    = rd;
        bus.redirect_pc_in = rpc;
        #2;
        exp_req = rst && !m_halt && !rd && (mq.size() + 2 * int'(m_pend) <= DEPTH - 2);
        chk("imem_req", 32'(bus.imem_req_out), 32'(exp_req));
        if (exp_req) begin
            nxt = m_fpc + 8'd1;
            chk("imem_addr0", 32'(bus.imem_addr0_out), 32'(m_fpc));
            chk("imem_addr1", 32'(bus.imem_addr1_out), 32'(nxt));
        end
        dreq = bus.imem_req_out;
        da0  = bus.imem_addr0_out;
        da1  = bus.imem_addr1_out;

        if (!rst) begin
            mq.delete(); m_fpc = 0; m_pend = 0; m_halt = 0; model_clear_slots();
        end else if (rd) begin
            mq.delete(); m_fpc = rpc; m_pend = 0; m_halt = 0; model_clear_slots();
        end else begin
            if (!st) begin
                if (m_halt) model_clear_slots();
                else begin
                    m_v0 = mq.size() >= 1;
                    m_s0 = m_v0 ? mq[0] : '0;
                    m_v1 = mq.size() >= 2 && pairable(mq[0], mq[1]);
                    m_s1 = m_v1 ? mq[1] : '0;
                    if (m_v0) void'(mq.pop_front());
                    if (m_v1) void'(mq.pop_front());
                    if (m_v0 && m_s0.ir[15:13] == 3'd7) m_halt = 1;
                end
            end
            if (m_pend) begin
                p1 = m_pend_pc + 8'd1;
                mq.push_back('{pc: m_pend_pc, ir: mem[m_pend_pc]});
                mq.push_back('{pc: p1, ir: mem[p1]});
            end
            m_pend = exp_req;
            if (exp_req) begin
                m_pend_pc = m_fpc;
                m_fpc     = m_fpc + 8'd2;
            end
        end

        @(posedge clk);
        #1;
        chk("p0_valid", 32'(bus.p0_valid_out), 32'(m_v0));
        chk("p0_IR",    32'(bus.p0_IR_out),    32'(m_s0.ir));
        chk("p0_PC",    32'(bus.p0_PC_out),    32'(m_s0.pc));
        chk("p1_valid", 32'(bus.p1_valid_out), 32'(m_v1));
        chk("p1_IR",    32'(bus.p1_IR_out),    32'(m_s1.ir));
        chk("p1_PC",    32'(bus.p1_PC_out),    32'(m_s1.pc));
        chk("halted",   32'(bus.halted_out),   32'(m_halt));

        if (dreq) begin
            bus.imem_rdata0_in = mem[da0];
            bus.imem_rdata1_in = mem[da1];
        end else begin
            bus.imem_rdata0_in = 16'($urandom);
            bus.imem_rdata1_in = 16'($urandom);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(0, 0, 8'h00);
        rst = 1'b1;
    endtask

    task automatic fill_zero();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic fill_random(input bit allow_ctrl);
        logic [2:0] op;
        for (int i = 0; i < 256; i++) begin
            op = 3'($urandom_range(0, 7));
            if (!allow_ctrl && is_ctrl({op, 13'h0})) op = 3'd5;
            if (allow_ctrl && op == 3'd7 && $urandom_range(0, 3) != 0) op = 3'd6;
            mem[i] = {op, 13'($urandom)};
        end
    endtask

    initial begin
        bus.stall_in       = 1'b0;
        bus.redirect_in    = 1'b0;
        bus.redirect_pc_in = 8'h00;
        bus.imem_rdata0_in = 16'h0000;
        bus.imem_rdata1_in = 16'h0000;
        fill_zero();
        @(posedge clk);
        #1;

        // Reset: all outputs zero; redirect during reset is ignored.
        rst = 1'b0;
        step(0, 1, 8'h55);
        step(1, 0, 8'h00);
        rst = 1'b1;

        // Independent pairs issue back to back.
        mem[0] = enc(3'd5, 2'd0, 3'd2, 3'd1, 5'd3);
        mem[1] = enc(3'd5, 2'd0, 3'd5, 3'd4, 5'd6);
        mem[2] = enc(3'd6, 2'd2, 3'd7, 3'd0, 5'd1);
        mem[3] = enc(3'd6, 2'd2, 3'd0, 3'd0, 5'd2);
        do_reset();
        run(3);
        chk("t1_pair0_p0pc", 32'(bus.p0_PC_out), 32'h00);
        chk("t1_pair0_p1pc", 32'(bus.p1_PC_out), 32'h01);
        chk("t1_pair0_v", 32'({bus.p0_valid_out, bus.p1_valid_out}), 32'h3);
        run(1);
        chk("t1_pair1_p0pc", 32'(bus.p0_PC_out), 32'h02);
        chk("t1_pair1_p1pc", 32'(bus.p1_PC_out), 32'h03);
        chk("t1_pair1_v", 32'({bus.p0_valid_out, bus.p1_valid_out}), 32'h3);
        run(3);

        // RAW hazard inside a pair splits it.
        fill_zero();
        mem[0] = enc(3'd6, 2'd2, 3'd1, 3'd0, 5'd5);
        mem[1] = enc(3'd5, 2'd0, 3'd1, 3'd2, 5'd3);
        do_reset();
        run(3);
        chk("t2_p0pc", 32'(bus.p0_PC_out), 32'h00);
        chk("t2_p1v", 32'(bus.p1_valid_out), 32'h0);
        run(1);
        chk("t2_next_p0pc", 32'(bus.p0_PC_out), 32'h01);
        run(2);

        // Branch alone, then redirect to 0x40.
        fill_zero();
        mem[0] = 16'h2000;
        mem[1] = enc(3'd5, 2'd0, 3'd2, 3'd1, 5'd3);
        do_reset();
        run(3);
        chk("t3_branch_ir", 32'(bus.p0_IR_out), 32'h2000);
        chk("t3_branch_alone", 32'(bus.p1_valid_out), 32'h0);
        step(0, 1, 8'h40);
        chk("t3_redirect_v", 32'({bus.p0_valid_out, bus.p1_valid_out}), 32'h0);
        run(3);
        chk("t3_target_pc", 32'(bus.p0_PC_out), 32'h40);
        chk("t3_target_v", 32'(bus.p0_valid_out), 32'h1);
        run(2);

        // Stall held three cycles mid-stream.
        fill_random(0);
        do_reset();
        run(4);
        step(1, 0, 8'h00); step(1, 0, 8'h00); step(1, 0, 8'h00);
        run(6);

        // PC wrap at 0xFE.
        fill_zero();
        step(0, 1, 8'hFE);
        run(3);
        chk("t5_wrap_p0", 32'(bus.p0_PC_out), 32'hFE);
        chk("t5_wrap_p1", 32'(bus.p1_PC_out), 32'hFF);
        run(1);
        chk("t5_wrap_next_p0", 32'(bus.p0_PC_out), 32'h00);
        chk("t5_wrap_next_p1", 32'(bus.p1_PC_out), 32'h01);

        // HALT at PC2 freezes fetch and issue until reset.
        fill_zero();
        mem[2] = 16'hE000;
        do_reset();
        run(8);
        chk("t6_halted", 32'(bus.halted_out), 32'h1);
        chk("t6_req_off", 32'(bus.imem_req_out), 32'h0);
        do_reset();
        chk("t6_reset_halt", 32'(bus.halted_out), 32'h0);
        run(4);

        // Random phase.
        fill_random(1);
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                fill_random(1);
                do_reset();
            end else begin
                step(r < 27, r >= 95, 8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
